// File: rtl/fifo_uart_pkg.sv
// Shared types and framing constants for the FIFO-fed UART transmitter.
// PARITY is always declared; it is only reachable when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StStart,
        StData,
        StStop,
        StParity
    } tx_state_t;

    localparam int unsigned FRAME_BITS_8N1 = 10;
    localparam int unsigned FRAME_BITS_8E1 = 11;

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-period counter, restartable on state entry; reusable by a future RX stage.
// tick is a look-ahead: high in the cycle before the last cycle of each bit period.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (restart || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    // Lets the parent register outputs that must line up with the last cycle of a period.
    assign tick = (cnt_d == CntMax);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and serialises them as UART frames (8N1, LSB first).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              period_end_q;
    logic              tick, restart;
    logic              tx_q, tx_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign restart = (state_d != state_q);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StFetch;
            StFetch: state_d = StLatch;
            // dout is only valid this cycle; capture at the exit edge.
            StLatch: begin
                state_d   = StStart;
                shift_d   = fifo_dout;
                bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d  = ^fifo_dout;
`endif
            end
            StStart: if (period_end_q) state_d = StData;
            StData: begin
                if (period_end_q) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitLast) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            StParity: if (period_end_q) state_d = StStop;
`endif
            StStop:  if (period_end_q) state_d = fifo_empty ? StIdle : StFetch;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so the registered copies align with state_q.
        rd_en_d = (state_d == StFetch);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StStop) && tick;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            period_end_q <= 1'b0;
            tx_q         <= 1'b1;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            period_end_q <= tick;
            tx_q         <= tx_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx with a behavioural FIFO and a UART frame decoder.
// Honours FIFO_UART_TX_PARITY_EN to check 8E1 framing.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int unsigned CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned NB         = FRAME_BITS_8E1;
    localparam int          FRAME_CYC  = 44;
    localparam int          RD_TO_IDLE = 46;
`else
    localparam int unsigned NB         = FRAME_BITS_8N1;
    localparam int          FRAME_CYC  = 40;
    localparam int          RD_TO_IDLE = 42;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout  = 8'h00;
    logic       fifo_rd_en, tx, busy, frame_done;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int n_frames = 0;
    int empty_fall_cyc = 0;
    logic [7:0] fq[$];
    exp_t       exp_q[$];
    int         rd_cycles[$];
    int         start_cycles[$];

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_idle(input int n_rd, output int idle_cyc);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rd_cycles.size() >= n_rd && !busy) begin
                idle_cyc = cyc;
                return;
            end
        end
        check("wait_timeout_rd_count", rd_cycles.size(), n_rd);
        check("wait_timeout_busy", busy, 0);
        idle_cyc = cyc;
    endtask

    // FIFO model: data valid for one cycle after the edge that samples rd_en.
    initial begin : fifo_model
        logic prev_rd;
        logic old_empty;
        prev_rd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                prev_rd   = 1'b0;
                fifo_dout = 8'h00;
            end else begin
                if (prev_rd) begin
                    check("pop_while_nonempty", fq.size() != 0, 1);
                    fifo_dout = (fq.size() != 0) ? fq.pop_front() : 8'h00;
                end else begin
                    fifo_dout = 8'h00;
                end
                prev_rd = fifo_rd_en;
            end
            old_empty  = fifo_empty;
            fifo_empty = (fq.size() == 0);
            if (old_empty && !fifo_empty) empty_fall_cyc = cyc;
        end
    end

    initial begin : rd_monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && fifo_rd_en) begin
                check("rd_en_single_cycle", prev, 0);
                rd_cycles.push_back(cyc);
            end
            if (rst && frame_done) fd_cnt++;
            prev = fifo_rd_en;
        end
    end

    // Decodes frames at mid-bit and checks them against the scoreboard.
    initial begin : frame_monitor
        logic          in_frame;
        int            pos;
        logic [NB-1:0] bits;
        exp_t          e;
        in_frame = 1'b0;
        pos      = 0;
        bits     = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx == 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 0;
                    start_cycles.push_back(cyc);
                end
            end else begin
                pos++;
            end
            if (rst && in_frame && (pos % CPB) == CPB / 2) begin
                bits[pos/CPB] = tx;
                if (pos / CPB == NB - 1) begin
                    in_frame = 1'b0;
                    n_frames++;
                    check("start_bit", bits[0], 0);
                    check("stop_bit", bits[NB-1], 1);
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("data_byte", bits[8:1], e.data);
`ifdef FIFO_UART_TX_PARITY_EN
                        check("parity_bit", bits[9], e.par);
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int idle_cyc;
        int base;
        int target;
        logic seen_rd, seen_low;

        // Reset held with a non-empty FIFO.
        fq.push_back(8'hA5);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_rd_en", fifo_rd_en, 0);
            check("rst_busy", busy, 0);
            check("rst_frame_done", frame_done, 0);
        end

        // Single byte 0xA5.
        exp_q.push_back('{data: 8'hA5, par: 1'b0});
        rd_cycles.delete();
        fd_cnt = 0;
        base   = n_frames;
        @(posedge clk);
        #2 rst = 1'b1;
        wait_idle(1, idle_cyc);
        check("a5_rd_count", rd_cycles.size(), 1);
        check("a5_rd_to_idle", idle_cyc - rd_cycles[0], RD_TO_IDLE);
        check("a5_frame_done_count", fd_cnt, 1);
        check("a5_frames_decoded", n_frames - base, 1);

        // Back-to-back 0x00 then 0xFF.
        rd_cycles.delete();
        start_cycles.delete();
        fd_cnt = 0;
        base   = n_frames;
        @(posedge clk);
        #2;
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        exp_q.push_back('{data: 8'h00, par: 1'b0});
        exp_q.push_back('{data: 8'hFF, par: 1'b0});
        wait_idle(2, idle_cyc);
        check("b2b_rd_count", rd_cycles.size(), 2);
        check("b2b_rd_spacing", rd_cycles[1] - rd_cycles[0], RD_TO_IDLE);
        check("b2b_rd_after_empty_fall", rd_cycles[0] - empty_fall_cyc, 1);
        check("b2b_gap", start_cycles[1] - start_cycles[0] - FRAME_CYC, 2);
        check("b2b_frame_done_count", fd_cnt, 2);
        check("b2b_frames_decoded", n_frames - base, 2);

        // Empty FIFO for 100 cycles.
        seen_rd  = 1'b0;
        seen_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd_en) seen_rd = 1'b1;
            if (tx !== 1'b1) seen_low = 1'b1;
        end
        check("empty_no_rd_en", seen_rd, 0);
        check("empty_tx_high", seen_low, 0);

        // Reset during the third data bit of 0x5A (bit 2 = 0).
        rd_cycles.delete();
        base = n_frames;
        @(posedge clk);
        #2;
        fq.push_back(8'h5A);
        exp_q.push_back('{data: 8'h5A, par: 1'b0});
        for (int i = 0; i < 100 && rd_cycles.size() == 0; i++) @(negedge clk);
        check("mid_rd_seen", rd_cycles.size(), 1);
        target = rd_cycles[0] + 15;
        for (int i = 0; i < 100 && cyc != target; i++) @(negedge clk);
        check("mid_reached_bit2", cyc, target);
        check("mid_tx_before_reset", tx, 0);
        rst = 1'b0;
        #1;
        check("mid_reset_tx", tx, 1);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        rd_cycles.delete();
        fd_cnt = 0;
        fq.push_back(8'h96);
        exp_q.push_back('{data: 8'h96, par: 1'b0});
        wait_idle(1, idle_cyc);
        check("post_rst_rd_to_idle", idle_cyc - rd_cycles[0], RD_TO_IDLE);
        check("post_rst_frames_decoded", n_frames - base, 1);
        check("post_rst_frame_done_count", fd_cnt, 1);
        check("post_rst_scoreboard_empty", exp_q.size(), 0);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity: 0x07 -> 1, 0x03 -> 0.
        rd_cycles.delete();
        start_cycles.delete();
        base = n_frames;
        @(posedge clk);
        #2;
        fq.push_back(8'h07);
        fq.push_back(8'h03);
        exp_q.push_back('{data: 8'h07, par: 1'b1});
        exp_q.push_back('{data: 8'h03, par: 1'b0});
        wait_idle(2, idle_cyc);
        check("par_frame_len", start_cycles[1] - start_cycles[0] - 2, 44);
        check("par_rd_spacing", rd_cycles[1] - rd_cycles[0], 46);
        check("par_frames_decoded", n_frames - base, 2);
`endif

        repeat (5) @(negedge clk);
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Drain stage sitting directly downstream of the 8-bit 1 KB FIFO. It pops one byte at a time using the FIFO's rd_en/empty/dout interface and serialises each byte as an asynchronous UART frame (8N1, LSB first) on a single output line. It runs continuously while the FIFO holds data and returns to idle when the FIFO reports empty.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range is 2 or more.
DATA_W, 8, byte width; must match the FIFO data width.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-low reset.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  DATA_W  FIFO read data; valid in the cycle after the edge that sampled rd_en=1.
fifo_rd_en  output  1  FIFO pop request; one-cycle pulse.
tx  output  1  serial line; idles high.
busy  output  1  high in every state except IDLE.
frame_done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0. The shift register, bit counter and baud counter are all cleared.
- All outputs are registered.
- FSM states: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE: if fifo_empty=0, go to FETCH. Otherwise stay in IDLE.
- FETCH: fifo_rd_en=1 for exactly this one cycle, then go to LATCH.
- LATCH: capture fifo_dout into the shift register at the exit edge, then go to START.
  - The FIFO clears dout once rd_en drops, so the capture must happen at this edge and no later.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift register bit 0. Shift right each bit period. After DATA_W bits, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done pulses on the last cycle of STOP. Then:
  - if fifo_empty=0, go directly to FETCH (back-to-back frames);
  - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts on every state entry. Width is $clog2(CLKS_PER_BIT).
- Frame timing: fifo_rd_en rises 1 cycle after fifo_empty falls while in IDLE. tx falls 2 cycles after the rd_en pulse. One frame is 10*CLKS_PER_BIT cycles. Inter-frame gap when back-to-back is 2 cycles (FETCH + LATCH) of tx=1.
- fifo_empty is sampled only in IDLE and on STOP exit. Changes at any other time are ignored.
- Never pop while fifo_empty=1. fifo_rd_en is never high for two consecutive cycles.
- Reset mid-frame: tx returns to 1 immediately. The byte in flight is lost. The FIFO pointer is not restored.

Optional Feature:
Macro: FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the DATA_W data bits) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state exists; 8N1 framing as above.

Decomposition:
- Package fifo_uart_pkg contains:
  - typedef enum logic [2:0] tx_state_t, covering IDLE, FETCH, LATCH, START, DATA, STOP and PARITY (PARITY is always declared);
  - localparams FRAME_BITS_8N1=10 and FRAME_BITS_8E1=11.
- Sub-module baud_tick_gen (parameter CLKS_PER_BIT; inputs clk, rst, restart; output tick). It encapsulates the baud counter and is the natural reuse point for a future RX stage.

Test Plan:
- Reset: hold rst=0 for 5 cycles with fifo_empty=0 -> tx=1, fifo_rd_en=0, busy=0 throughout.
- Single byte 0xA5, CLKS_PER_BIT=4, FIFO holds one entry:
  - exactly one fifo_rd_en pulse;
  - tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1;
  - one frame_done pulse;
  - return to IDLE with busy=0 after 42 cycles from rd_en.
- Back-to-back 0x00 then 0xFF:
  - two rd_en pulses 42 cycles apart;
  - 2-cycle tx=1 gap between frames;
  - decoded bytes are 0x00 and 0xFF in order.
- Empty FIFO: fifo_empty=1 for 100 cycles -> fifo_rd_en never asserted, tx=1 constant.
- Mid-frame reset: drive rst=0 during the 3rd data bit -> tx=1 within the same cycle, state=IDLE. The next byte is sent as a clean full frame.
- With FIFO_UART_TX_PARITY_EN, byte 0x07 -> parity bit=1 and frame length 44 cycles. Byte 0x03 -> parity bit=0.
